mips_bus_memory: RTL and testbench

MIPS_BUS_MEMORY -- requirements
Module: mips_bus_memory

---
 rtl/mips_bus_memory.sv | 104 ++++++++++
 tb/tb_mips_bus_memory.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_memory.sv
// Word-addressed 32-bit memory slave on an Avalon-style bus with fixed wait states.
// Byte-lane writes; illegal accesses complete normally but raise a sticky bus_error.
module mips_bus_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        bus_error
);

  localparam int         AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_count;
  logic [3:0]  w_count_next;
  logic        r_rd_en;
  logic        r_bus_error;
  logic        w_req;
  logic        w_legal;
  logic        w_we;
  logic [29:0] w_word;
  logic [AW-1:0] w_index;
  logic [31:0] w_mem_q;

  // BASE_ADDR is word aligned, so subtracting word addresses gives (address-BASE)>>2.
  assign w_word  = address[31:2] - BASE_ADDR[31:2];
  assign w_index = w_word[AW-1:0];
  assign w_req   = read | write;
  assign w_legal = (address[1:0] == 2'b00) && ({2'b00, w_word} < 32'(DEPTH_WORDS))
                   && !(read && write);
  assign w_we    = reset && (r_state == ACK) && write && w_legal;

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_count_next = WS;
          w_state_next = (WS != 4'd0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_state_next = IDLE;
          w_count_next = 4'd0;
        end else begin
          w_count_next = r_count - 4'd1;
          if (r_count == 4'd1) w_state_next = ACK;
        end
      end
      ACK:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_count     <= 4'd0;
      r_rd_en     <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      // Memory output register is captured on the same edge that enters ACK.
      r_rd_en <= (w_state_next == ACK) && read && w_legal;
      if ((r_state == ACK) && w_req && !w_legal) r_bus_error <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_q;

      always_ff @(posedge clk) begin
        if (w_we && byteenable[gi]) r_mem[w_index] <= writedata[8*gi +: 8];
        r_q <= r_mem[w_index];
      end

      assign w_mem_q[8*gi +: 8] = r_q;
    end
  endgenerate

  assign waitrequest = !reset || (w_req && (r_state != ACK));
  assign readdata    = r_rd_en ? w_mem_q : 32'd0;
  assign bus_error   = r_bus_error;

endmodule

// File: tb/tb_mips_bus_memory.sv
// Scoreboard bench: the driver queues expected completions, a monitor checks each
// completion (readdata, latency, bus_error) and idle/busy cycles as they occur.
module tb_mips_bus_memory;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BBASE = 32'h00001000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_read, a_write, a_wait, a_berr;
  logic [3:0]  a_be;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_read, b_write, b_wait, b_berr;
  logic [3:0]  b_be;

  mips_bus_memory #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(reset), .address(a_addr), .read(a_read), .write(a_write),
    .writedata(a_wdata), .byteenable(a_be), .waitrequest(a_wait),
    .readdata(a_rdata), .bus_error(a_berr)
  );

  mips_bus_memory #(.BASE_ADDR(BBASE), .DEPTH_WORDS(16), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset), .address(b_addr), .read(b_read), .write(b_write),
    .writedata(b_wdata), .byteenable(b_be), .waitrequest(b_wait),
    .readdata(b_rdata), .bus_error(b_berr)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        berr;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for dut_a: every completion pops one expected entry.
  initial begin : monitor
    int   wait_cnt;
    exp_t e;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        wait_cnt = 0;
      end else if (!(a_read || a_write)) begin
        wait_cnt = 0;
        chk("idle_waitrequest", 32'(a_wait), 32'd0);
        chk("idle_readdata", a_rdata, 32'd0);
      end else if (a_wait) begin
        wait_cnt++;
        chk("busy_readdata", a_rdata, 32'd0);
      end else begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_completion: got readdata %h, expected no completion", a_rdata);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_rdata"}, a_rdata, e.rdata);
          chk({e.name, "_latency"}, 32'(wait_cnt), 32'd3);
          chk({e.name, "_berr"}, 32'(a_berr), 32'(e.berr));
          $display("xfer %s: readdata=%h bus_error=%0b busy_cycles=%0d",
                   e.name, a_rdata, a_berr, wait_cnt);
        end
        wait_cnt = 0;
      end
    end
  end

  task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rdata, input logic exp_berr,
                      input string name, input int n = 1);
    exp_t e;
    int   done;
    for (int k = 0; k < n; k++) begin
      e.rdata = exp_rdata;
      e.berr  = exp_berr;
      e.name  = name;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    a_read = rd; a_write = wr; a_addr = addr; a_wdata = wdata; a_be = be;
    done = 0;
    for (int c = 0; c < 40 && done < n; c++) begin
      @(negedge clk);
      if (!a_wait) done++;
    end
    if (done < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d completions, expected %0d", name, done, n);
      sb.delete();
    end
    @(posedge clk); #1;
    a_read = 1'b0; a_write = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic        b_exp_w [4];
  logic [31:0] b_exp_r [4];

  initial begin : driver
    reset = 1'b0;
    a_addr = '0; a_wdata = '0; a_be = '0; a_read = 1'b0; a_write = 1'b0;
    b_addr = '0; b_wdata = '0; b_be = '0; b_read = 1'b0; b_write = 1'b0;
    b_exp_w = '{1'b1, 1'b0, 1'b1, 1'b0};
    b_exp_r = '{32'd0, 32'h12345678, 32'd0, 32'h12345678};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_waitrequest_a", 32'(a_wait), 32'd1);
    chk("reset_waitrequest_b", 32'(b_wait), 32'd1);
    chk("reset_readdata", a_rdata, 32'd0);
    chk("reset_bus_error", 32'(a_berr), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_waitrequest", 32'(a_wait), 32'd0);

    // Zero wait states: write, then a held read completing at T+1 and T+3.
    @(posedge clk); #1;
    b_addr = BBASE + 32'd12; b_wdata = 32'h12345678; b_be = 4'hF; b_write = 1'b1;
    @(negedge clk);
    chk("b_write_busy", 32'(b_wait), 32'd1);
    @(negedge clk);
    chk("b_write_ack", 32'(b_wait), 32'd0);
    @(posedge clk); #1;
    b_write = 1'b0;
    @(posedge clk); #1;
    b_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b_held_read_wait%0d", i), 32'(b_wait), 32'(b_exp_w[i]));
      chk($sformatf("b_held_read_data%0d", i), b_rdata, b_exp_r[i]);
    end
    @(posedge clk); #1;
    b_read = 1'b0;
    $display("xfer b_held_read: two completions checked");

    xfer(1'b0, 1'b1, BASE + 32'd8,  32'hDEADBEEF, 4'hF, 32'd0,         1'b0, "wr_deadbeef");
    xfer(1'b1, 1'b0, BASE + 32'd8,  32'd0,        4'h0, 32'hDEADBEEF,  1'b0, "rd_deadbeef");
    xfer(1'b0, 1'b1, BASE + 32'd16, 32'h11223344, 4'hF, 32'd0,         1'b0, "wr_full");
    xfer(1'b0, 1'b1, BASE + 32'd16, 32'hAABBCCDD, 4'h5, 32'd0,         1'b0, "wr_partial");
    xfer(1'b1, 1'b0, BASE + 32'd16, 32'd0,        4'h0, 32'h11BB33DD,  1'b0, "rd_partial");
    xfer(1'b0, 1'b1, BASE + 32'd20, 32'h55667788, 4'hF, 32'd0,         1'b0, "wr_full2");
    xfer(1'b0, 1'b1, BASE + 32'd20, 32'hCAFEF00D, 4'h0, 32'd0,         1'b0, "wr_be0");
    xfer(1'b1, 1'b0, BASE + 32'd20, 32'd0,        4'h0, 32'h55667788,  1'b0, "rd_be0");
    xfer(1'b0, 1'b1, BASE,          32'h01020304, 4'hF, 32'd0,         1'b0, "wr_word0");
    xfer(1'b0, 1'b1, BASE + 32'd4092, 32'h0BADF00D, 4'hF, 32'd0,       1'b0, "wr_last");
    xfer(1'b1, 1'b0, BASE + 32'd4092, 32'd0,      4'h0, 32'h0BADF00D,  1'b0, "rd_last");
    xfer(1'b1, 1'b0, BASE + 32'd8,  32'd0,        4'h0, 32'hDEADBEEF,  1'b0, "rd_b2b", 2);

    // Request withdrawn during WAIT: no write takes place.
    @(posedge clk); #1;
    a_addr = BASE + 32'd8; a_wdata = 32'h0; a_be = 4'hF; a_write = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    a_write = 1'b0;
    xfer(1'b1, 1'b0, BASE + 32'd8, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, "rd_after_drop");

    // Reset asserted during WAIT of a write to word 0.
    @(posedge clk); #1;
    a_addr = BASE; a_wdata = 32'hFFFFFFFF; a_be = 4'hF; a_write = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wait_held", 32'(a_wait), 32'd1);
    @(posedge clk); #1;
    a_write = 1'b0;
    @(negedge clk);
    chk("rst_wait_forced", 32'(a_wait), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_released_idle", 32'(a_wait), 32'd0);
    xfer(1'b1, 1'b0, BASE, 32'd0, 4'h0, 32'h01020304, 1'b0, "rd_after_reset");

    // Illegal accesses.
    xfer(1'b1, 1'b0, BASE + 32'd2, 32'd0, 4'h0, 32'd0, 1'b0, "rd_unaligned");
    @(negedge clk);
    chk("berr_sticky", 32'(a_berr), 32'd1);
    xfer(1'b0, 1'b1, BASE + 32'(4 * DEPTH), 32'h99999999, 4'hF, 32'd0, 1'b1, "wr_out_of_range");
    xfer(1'b1, 1'b0, BASE,           32'd0, 4'h0, 32'h01020304, 1'b1, "rd_word0_intact");
    xfer(1'b1, 1'b0, BASE - 32'd4,   32'd0, 4'h0, 32'd0,        1'b1, "rd_below_base");

    // Both read and write high, from a fresh reset so bus_error must rise.
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("berr_cleared", 32'(a_berr), 32'd0);
    xfer(1'b1, 1'b1, BASE + 32'd8, 32'h0, 4'hF, 32'd0, 1'b0, "rd_wr_both");
    @(negedge clk);
    chk("berr_both", 32'(a_berr), 32'd1);
    xfer(1'b1, 1'b0, BASE + 32'd8, 32'd0, 4'h0, 32'hDEADBEEF, 1'b1, "rd_after_both");

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
